// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding, default datapath width and small op-decode helpers.
package mul_div_unit_pkg;

  localparam int MD_DWIDTH = 32;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIX  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_t;

  function automatic logic md_op_is_div(input logic [2:0] op);
    return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
  endfunction

  function automatic logic md_op_is_rem(input logic [2:0] op);
    return op inside {MD_OP_REM, MD_OP_REMU};
  endfunction

  // Multiplies that return the upper half of the product.
  function automatic logic md_op_high(input logic [2:0] op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU};
  endfunction

  function automatic logic md_op_signed_a(input logic [2:0] op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
  endfunction

  function automatic logic md_op_signed_b(input logic [2:0] op);
    return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute-stage control path (master)
// and the multiply/divide unit (slave). Flush travels with the request side.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int DWIDTH = MD_DWIDTH
);
  logic              Flush;
  logic              In_Valid;
  logic              In_Ready;
  logic [DWIDTH-1:0] MD_In_A;
  logic [DWIDTH-1:0] MD_In_B;
  logic [2:0]        MD_OP;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [DWIDTH-1:0] MD_Out;
  logic              MD_Zero_Flag;

  modport master (
    output Flush, In_Valid, MD_In_A, MD_In_B, MD_OP, Out_Ready,
    input  In_Ready, Out_Valid, MD_Out, MD_Zero_Flag
  );

  modport slave (
    input  Flush, In_Valid, MD_In_A, MD_In_B, MD_OP, Out_Ready,
    output In_Ready, Out_Valid, MD_Out, MD_Zero_Flag
  );
endinterface

// File: rtl/mul_div_unit_step.sv
// One iteration of the shared datapath. Multiply: shift-add on a product
// register whose low half initially holds the multiplier. Divide: restoring
// step on {remainder, quotient}, the quotient half initially holding the dividend.
module mul_div_step #(
  parameter int DWIDTH = 32
) (
  input  logic              is_div_i,
  input  logic [2*DWIDTH-1:0] acc_i,
  input  logic [DWIDTH-1:0] opnd_i,
  output logic [2*DWIDTH-1:0] acc_o
);

  logic [DWIDTH:0] mul_sum;
  logic [DWIDTH:0] div_trial;

  // Trial subtract borrows into bit DWIDTH exactly when the divisor does not fit.
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*DWIDTH-1:DWIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    div_trial = {acc_i[2*DWIDTH-1:DWIDTH], acc_i[DWIDTH-1]} - {1'b0, opnd_i};
    if (is_div_i) begin
      if (div_trial[DWIDTH]) acc_o = {acc_i[2*DWIDTH-2:0], 1'b0};
      else                   acc_o = {div_trial[DWIDTH-1:0], acc_i[DWIDTH-2:0], 1'b1};
    end else begin
      acc_o = {mul_sum, acc_i[DWIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multi-cycle multiply/divide unit. Operates on magnitudes and fixes
// the sign once at the end. Divide-by-zero and signed overflow finish
// straight from IDLE. Build option MD_FAST_MUL_EN: multiplies use a
// single-cycle combinational multiplier instead of the iterative path.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one multiply/divide iteration per cycle, counter DWIDTH-1 .. 0
// FIX   | sign correction and half select into the result register
// DONE  | result valid, held until Out_Ready
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DWIDTH = MD_DWIDTH,
  parameter int CWIDTH = 6
) (
  input logic Clk,
  input logic Reset,
  mul_div_unit_if.slave md
);

  localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(DWIDTH - 1);

  md_state_t           state_q, state_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0]   opnd_q, opnd_d;
  logic [DWIDTH-1:0]   md_out_q, md_out_d;
  logic                zero_q, zero_d;

  logic                in_div, in_rem, a_neg, b_neg, res_neg, ovf, accept;
  logic [DWIDTH-1:0]   mag_a, mag_b;
  logic                early_done;
  logic [DWIDTH-1:0]   early_res;
  logic [2*DWIDTH-1:0] step_acc, mul_fix;
  logic [DWIDTH-1:0]   div_sel, fix_res;

  mul_div_step #(.DWIDTH(DWIDTH)) u_step (
    .is_div_i (md_op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // Decode of the incoming request: magnitudes, result sign, shortcut cases.
  always_comb begin
    in_div  = md_op_is_div(md.MD_OP);
    in_rem  = md_op_is_rem(md.MD_OP);
    a_neg   = md_op_signed_a(md.MD_OP) & md.MD_In_A[DWIDTH-1];
    b_neg   = md_op_signed_b(md.MD_OP) & md.MD_In_B[DWIDTH-1];
    mag_a   = a_neg ? -md.MD_In_A : md.MD_In_A;
    mag_b   = b_neg ? -md.MD_In_B : md.MD_In_B;
    res_neg = in_rem ? a_neg : (a_neg ^ b_neg);
    ovf     = in_div && md_op_signed_a(md.MD_OP) &&
              (md.MD_In_A == {1'b1, {(DWIDTH-1){1'b0}}}) && (md.MD_In_B == '1);
    accept  = md.In_Valid && (state_q == MD_ST_IDLE) && !md.Flush;
  end

`ifdef MD_FAST_MUL_EN
  logic [2*DWIDTH-1:0] fast_a, fast_b, fast_prod;

  // Operands extended per signedness; the low 2*DWIDTH bits of the product are exact.
  always_comb begin
    fast_a    = md_op_signed_a(md.MD_OP) ? {{DWIDTH{md.MD_In_A[DWIDTH-1]}}, md.MD_In_A}
                                         : {{DWIDTH{1'b0}}, md.MD_In_A};
    fast_b    = md_op_signed_b(md.MD_OP) ? {{DWIDTH{md.MD_In_B[DWIDTH-1]}}, md.MD_In_B}
                                         : {{DWIDTH{1'b0}}, md.MD_In_B};
    fast_prod = fast_a * fast_b;
  end
`endif

  // Operations that complete directly from IDLE and their results.
  always_comb begin
    early_done = 1'b0;
    early_res  = '0;
    if (in_div && (md.MD_In_B == '0)) begin
      early_done = 1'b1;
      early_res  = in_rem ? md.MD_In_A : '1;
    end else if (ovf) begin
      early_done = 1'b1;
      early_res  = in_rem ? '0 : md.MD_In_A;
    end
`ifdef MD_FAST_MUL_EN
    else if (!in_div) begin
      early_done = 1'b1;
      early_res  = md_op_high(md.MD_OP) ? fast_prod[2*DWIDTH-1:DWIDTH] : fast_prod[DWIDTH-1:0];
    end
`endif
  end

  // Sign correction: the product is negated as a whole before the half select,
  // quotient/remainder are negated after selection.
  always_comb begin
    mul_fix = neg_q ? -acc_q : acc_q;
    div_sel = md_op_is_rem(op_q) ? acc_q[2*DWIDTH-1:DWIDTH] : acc_q[DWIDTH-1:0];
    if (md_op_is_div(op_q))     fix_res = neg_q ? -div_sel : div_sel;
    else if (md_op_high(op_q))  fix_res = mul_fix[2*DWIDTH-1:DWIDTH];
    else                        fix_res = mul_fix[DWIDTH-1:0];
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    md_out_d = md_out_q;
    zero_d   = zero_q;
    unique case (state_q)
      MD_ST_IDLE: begin
        if (accept) begin
          op_d  = md.MD_OP;
          neg_d = res_neg;
          cnt_d = CNT_LAST;
          if (in_div) begin
            acc_d  = {{DWIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{DWIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          if (early_done) begin
            state_d  = MD_ST_DONE;
            md_out_d = early_res;
            zero_d   = (early_res == '0);
          end else begin
            state_d  = MD_ST_CALC;
          end
        end
      end
      MD_ST_CALC: begin
        acc_d = step_acc;
        if (cnt_q == '0) state_d = MD_ST_FIX;
        else             cnt_d   = cnt_q - CWIDTH'(1);
      end
      MD_ST_FIX: begin
        md_out_d = fix_res;
        zero_d   = (fix_res == '0);
        state_d  = MD_ST_DONE;
      end
      MD_ST_DONE: begin
        if (md.Out_Ready) state_d = MD_ST_IDLE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
    if (md.Flush && (state_q != MD_ST_IDLE)) state_d = MD_ST_IDLE;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= MD_ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      md_out_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      md_out_q <= md_out_d;
      zero_q   <= zero_d;
    end
  end

  assign md.In_Ready     = (state_q == MD_ST_IDLE);
  assign md.Out_Valid    = (state_q == MD_ST_DONE);
  assign md.MD_Out       = md_out_q;
  assign md.MD_Zero_Flag = zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, randomized ops
// against a 64-bit arithmetic reference, backpressure, flush and reset.
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MD_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mul_div_unit_if #(.DWIDTH(W)) md_if();

  mul_div_unit #(.DWIDTH(W), .CWIDTH(6)) dut (
    .Clk   (clk),
    .Reset (rst),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!op[2] && FAST) return 1;
    return W + 2;
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (md_if.In_Ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_wait: In_Ready=%b, required 1 within 100 cycles", md_if.In_Ready);
    end
    md_if.In_Valid = 1'b1;
    md_if.MD_OP    = op;
    md_if.MD_In_A  = a;
    md_if.MD_In_B  = b;
    @(posedge clk);
    @(negedge clk);
    md_if.In_Valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (md_if.Out_Valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zf, output int lat);
    start_op(op, a, b);
    wait_valid(lat);
    res = md_if.MD_Out;
    zf  = md_if.MD_Zero_Flag;
    md_if.Out_Ready = 1'b1;
    @(negedge clk);
    md_if.Out_Ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({md_if.In_Ready, md_if.Out_Valid, md_if.MD_Zero_Flag} !== 3'b101 || md_if.MD_Out !== '0) begin
      n_err++;
      $display("FAIL reset: rdy/vld/zf=%b%b%b out=%h, required 101 out=0",
               md_if.In_Ready, md_if.Out_Valid, md_if.MD_Zero_Flag, md_if.MD_Out);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [11] = '{3'b000, 3'b011, 3'b100, 3'b110, 3'b111, 3'b100, 3'b110,
                              3'b100, 3'b110, 3'b000, 3'b101};
    logic [31:0] as  [11] = '{32'd7, 32'hFFFF_FFFF, -32'sd20, -32'sd20, 32'd20, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'd3, 32'd100};
    logic [31:0] bs  [11] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd6, 32'd6, 32'd6, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd7};
    logic [31:0] exs [11] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd12, 32'd14};
    int          lts [11] = '{FAST ? 1 : 34, FAST ? 1 : 34, 34, 34, 34, 1, 1, 1, 1,
                              FAST ? 1 : 34, 34};
    logic [31:0] res;
    logic        zf;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      run_op(ops[i], as[i], bs[i], res, zf, lat);
      n_cmp++;
      if (res !== exs[i] || zf !== (exs[i] == 0)) begin
        n_err++;
        $display("FAIL directed[%0d] op=%b: out=%h zf=%b, required out=%h zf=%b",
                 i, ops[i], res, zf, exs[i], exs[i] == 0);
      end
      n_cmp++;
      if (lat !== lts[i]) begin
        n_err++;
        $display("FAIL directed_latency[%0d] op=%b: %0d cycles, required %0d", i, ops[i], lat, lts[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, exp, res;
    logic        zf;
    int          lat, pick;
    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 20));
        3:       begin a = 32'($urandom_range(0, 50)); b = -32'($urandom_range(1, 9)); end
        default: b = $urandom;
      endcase
      exp = ref_result(op, a, b);
      run_op(op, a, b, res, zf, lat);
      n_cmp++;
      if (res !== exp) begin
        n_err++;
        $display("FAIL random_result op=%b a=%h b=%h: out=%h, required %h", op, a, b, res, exp);
      end
      n_cmp++;
      if (zf !== (exp == 0)) begin
        n_err++;
        $display("FAIL random_zero op=%b a=%h b=%h: zf=%b, required %b", op, a, b, zf, exp == 0);
      end
      n_cmp++;
      if (lat !== ref_latency(op, a, b)) begin
        n_err++;
        $display("FAIL random_latency op=%b: %0d cycles, required %0d", op, lat, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] exp;
    exp = ref_result(3'b100, 32'd1000, -32'sd7);
    start_op(3'b100, 32'd1000, -32'sd7);
    wait_valid(lat);
    md_if.In_Valid = 1'b1;
    md_if.MD_OP    = 3'b011;
    md_if.MD_In_A  = 32'h1234_5678;
    md_if.MD_In_B  = 32'h9abc_def0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (md_if.Out_Valid !== 1'b1 || md_if.In_Ready !== 1'b0 || md_if.MD_Out !== exp) begin
        n_err++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b out=%h, required vld=1 rdy=0 out=%h",
                 i, md_if.Out_Valid, md_if.In_Ready, md_if.MD_Out, exp);
      end
      @(negedge clk);
    end
    md_if.In_Valid  = 1'b0;
    md_if.Out_Ready = 1'b1;
    @(negedge clk);
    md_if.Out_Ready = 1'b0;
    n_cmp++;
    if (md_if.In_Ready !== 1'b1 || md_if.Out_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release: rdy=%b vld=%b, required rdy=1 vld=0",
               md_if.In_Ready, md_if.Out_Valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic        zf, seen;
    int          lat;
    start_op(3'b100, -32'sd100, 32'd7);
    repeat (4) @(negedge clk);
    md_if.Flush = 1'b1;
    @(negedge clk);
    md_if.Flush = 1'b0;
    n_cmp++;
    if (md_if.In_Ready !== 1'b1 || md_if.Out_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_calc: rdy=%b vld=%b, required rdy=1 vld=0", md_if.In_Ready, md_if.Out_Valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= md_if.Out_Valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_result: Out_Valid seen=%b, required 0", seen);
    end
    run_op(3'b101, 32'd100, 32'd7, res, zf, lat);
    n_cmp++;
    if (res !== 32'd14 || lat !== 34) begin
      n_err++;
      $display("FAIL flush_next_divu: out=%0d lat=%0d, required out=14 lat=34", res, lat);
    end
    // Flush coinciding with an accept cancels it.
    md_if.In_Valid = 1'b1;
    md_if.Flush    = 1'b1;
    md_if.MD_OP    = 3'b100;
    md_if.MD_In_A  = 32'd9;
    md_if.MD_In_B  = 32'd0;
    @(negedge clk);
    md_if.In_Valid = 1'b0;
    md_if.Flush    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (md_if.In_Ready !== 1'b1 || md_if.Out_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_with_accept: rdy=%b vld=%b, required rdy=1 vld=0",
               md_if.In_Ready, md_if.Out_Valid);
    end
    // Flush while a result is held drops it.
    start_op(3'b100, 32'd5, 32'd0);
    md_if.Flush = 1'b1;
    @(negedge clk);
    md_if.Flush = 1'b0;
    n_cmp++;
    if (md_if.In_Ready !== 1'b1 || md_if.Out_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_done: rdy=%b vld=%b, required rdy=1 vld=0", md_if.In_Ready, md_if.Out_Valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    start_op(3'b100, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    md_if.Flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    md_if.Flush = 1'b0;
    n_cmp++;
    if ({md_if.In_Ready, md_if.Out_Valid, md_if.MD_Zero_Flag} !== 3'b101 || md_if.MD_Out !== '0) begin
      n_err++;
      $display("FAIL reset_mid: rdy/vld/zf=%b%b%b out=%h, required 101 out=0",
               md_if.In_Ready, md_if.Out_Valid, md_if.MD_Zero_Flag, md_if.MD_Out);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= md_if.Out_Valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_result: Out_Valid seen=%b, required 0", seen);
    end
  endtask

  initial begin
    rst             = 1'b1;
    md_if.Flush     = 1'b0;
    md_if.In_Valid  = 1'b0;
    md_if.Out_Ready = 1'b0;
    md_if.MD_OP     = 3'b000;
    md_if.MD_In_A   = '0;
    md_if.MD_In_B   = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU in the execute stage; the control path stalls on In_Ready / Out_Valid.
- Iterative shift-add multiplier and restoring divider; one operation in flight at a time.

Parameters:
- DWIDTH, 32, operand/result width (must be even, >= 8).
- CWIDTH, 6, iteration counter width; must hold DWIDTH-1.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  abort in-flight operation (pipeline flush).
- In_Valid  input  1  operands/op valid.
- In_Ready  output  1  unit can accept (state IDLE).
- MD_In_A  input  DWIDTH  operand A (rs1).
- MD_In_B  input  DWIDTH  operand B (rs2).
- MD_OP  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Out_Valid  output  1  result valid; held until Out_Ready.
- Out_Ready  input  1  consumer takes result.
- MD_Out  output  DWIDTH  result.
- MD_Zero_Flag  output  1  MD_Out == 0, valid with Out_Valid.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; In_Ready=1; Out_Valid=0; MD_Out=0; MD_Zero_Flag=1; counter=0.
  - Reset mid-operation discards all work; no Out_Valid follows.
- Accept: In_Valid && In_Ready at a rising edge.
  - Latch op, operand magnitudes (signed ops take the absolute value) and result sign.
  - Go to CALC with counter=DWIDTH-1.
- States: IDLE, CALC, FIX, DONE.
- CALC:
  - Multiply: one shift-add step per cycle into a 2*DWIDTH product register.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - Counter decrements each cycle; at counter==0 go to FIX.
- FIX: apply sign correction.
  - Two's-complement negate the product if the sign flag is set.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Select the low or high half per op. Go to DONE.
- DONE:
  - Out_Valid=1; MD_Out and MD_Zero_Flag registered and stable.
  - Out_Ready=1 → IDLE next cycle; new input is not accepted in that same cycle.
- Latency: Out_Valid rises DWIDTH+2 cycles after the accept edge (34 for DWIDTH=32).
- Signedness:
  - MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU / DIVU / REMU: unsigned. DIV / REM: signed.
- Special cases, detected at accept; IDLE→DONE directly, Out_Valid 1 cycle after accept:
  - B==0: DIV/DIVU give all ones; REM/REMU give A.
  - Signed overflow (A = most negative, B = -1): DIV gives A; REM gives 0.
- Flush:
  - Any state except IDLE → IDLE next cycle, Out_Valid=0, no result delivered.
  - Flush in the same cycle as an accept cancels that accept.
  - Flush in IDLE has no effect.
  - Reset has priority over Flush.
- MD_OP values are all legal; there is no illegal-op path.
- In_Valid while not In_Ready is ignored; the producer holds its request.

Optional Feature:
- Macro MD_FAST_MUL_EN.
- Defined:
  - Multiply ops use a combinational DWIDTH x DWIDTH signed (DWIDTH+1)-bit multiply at accept, IDLE→DONE.
  - Multiply latency is 1 cycle. Divide behaviour is unchanged.
- Undefined:
  - Multiply is iterative, latency DWIDTH+2.
  - No hardware multiplier is inferred.

Decomposition:
- Shared defines/package holds:
  - MD_OP encodings (MD_OP_MUL … MD_OP_REMU).
  - State encodings (MD_ST_IDLE, MD_ST_CALC, MD_ST_FIX, MD_ST_DONE).
  - DWIDTH default.
- One natural sub-module: mul_div_step.
  - Combinational single iteration: shift-add for multiply or restoring trial-subtract for divide.
  - Parameterised by DWIDTH; selected by an is_div input.
- Top module owns the FSM, counter, sign logic and handshake.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD): MD_Out=0xFFFFFFEB, Out_Valid exactly 34 cycles after accept. MULHU 0xFFFFFFFF x 0xFFFFFFFF: MD_Out=0xFFFFFFFE.
- DIV A=-20, B=6: MD_Out=0xFFFFFFFD (-3). REM same operands: MD_Out=0xFFFFFFFE (-2). REMU 20 mod 6: MD_Out=2.
- DIV by zero, A=5, B=0: MD_Out=0xFFFFFFFF 1 cycle after accept. REM A=5, B=0: MD_Out=5. DIV 0x80000000 / 0xFFFFFFFF: MD_Out=0x80000000. REM same operands: MD_Out=0, MD_Zero_Flag=1.
- Backpressure: Out_Ready=0 for 10 cycles in DONE → Out_Valid and MD_Out stable, In_Ready=0. Then Out_Ready=1 → In_Ready=1 the next cycle.
- Flush asserted in CALC cycle 5 of a DIV → IDLE next cycle, no Out_Valid. Next DIVU 100/7 returns 14 with full latency.
- Reset asserted mid-CALC → all outputs at reset values next edge. With MD_FAST_MUL_EN defined: MUL 3 x 4 → MD_Out=12, 1 cycle after accept.
